// File: rtl/teeter_pkg.sv
// Shared types and defaults for the teeter-ball velocity/position datapath.
package teeter_pkg;

  localparam int FIX_W          = 32;
  localparam int POSITION_SHIFT = 4;
  localparam int POS_MIN_DEF    = 0;
  localparam int POS_MAX_DEF    = 100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCEL = 2'd1,
    CHECK = 2'd2,
    ISSUE = 2'd3
  } vel_state_t;

endpackage

// File: rtl/sat_add.sv
// Combinational signed add with a symmetric +/-LIMIT clamp; the sum is formed one bit wider so it cannot wrap.
import teeter_pkg::*;

module sat_add #(
  parameter int W     = FIX_W,
  parameter int LIMIT = 64
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);

  localparam logic signed [W:0] HI = (W+1)'(LIMIT);
  localparam logic signed [W:0] LO = -HI;

  logic signed [W:0] s;

  always_comb begin
    s = {a[W-1], a} + {b[W-1], b};
    if (s > HI)
      y = HI[W-1:0];
    else if (s < LO)
      y = LO[W-1:0];
    else
      y = s[W-1:0];
  end

endmodule

// File: rtl/velocity_ctrl.sv
// Frame-rate velocity engine: integrate, saturate, reflect at walls, then strobe the position integrator.
// Optional friction term enabled by defining VELOCITY_FRICTION_EN.
import teeter_pkg::*;

module velocity_ctrl #(
  parameter int POSITION_SHIFT = teeter_pkg::POSITION_SHIFT,
  parameter int POS_MIN        = POS_MIN_DEF,
  parameter int POS_MAX        = POS_MAX_DEF,
  parameter int VEL_MAX        = 64,
  parameter int DAMP_SHIFT     = 1,
  parameter int FRICTION_SHIFT = 3
) (
  input  logic                    CLK,
  input  logic                    i_rst_n,
  input  logic                    i_tick,
  input  logic signed [FIX_W-1:0] i_accel,
  input  logic signed [FIX_W-1:0] i_pos,
  input  logic                    i_hold,
  output logic signed [FIX_W-1:0] o_velocity,
  output logic                    o_calc_time,
  output logic                    o_bounce,
  output logic                    o_overrun,
  output logic                    o_busy
);

  if (DAMP_SHIFT < 1 || DAMP_SHIFT > 31) begin : g_bad_damp
    $error("DAMP_SHIFT must lie in 1..31");
  end
  if (POSITION_SHIFT < 0 || POSITION_SHIFT >= FIX_W) begin : g_bad_shift
    $error("POSITION_SHIFT must lie in 0..FIX_W-1");
  end

`ifdef VELOCITY_FRICTION_EN
  localparam bit FRICTION_EN = 1'b1;
`else
  localparam bit FRICTION_EN = 1'b0;
`endif

  vel_state_t              state_q, state_d;
  logic signed [FIX_W-1:0] vel_q, vel_d;
  logic                    bounce_q, bounce_d;
  logic                    overrun_q, overrun_d;

  logic signed [FIX_W-1:0] fric, vel_base, acc_sum;
  logic signed [FIX_W-1:0] vel_neg, vel_damp, refl_sum;
  logic                    hit_wall;

  // Friction is folded into the first operand: |v| <= VEL_MAX so v - (v>>>F)
  // never overflows, and one clamp after adding i_accel gives the same result.
  assign fric     = (vel_q >>> FRICTION_SHIFT) & {FIX_W{FRICTION_EN}};
  assign vel_base = vel_q - fric;
  assign vel_neg  = -vel_q;
  assign vel_damp = vel_q >>> DAMP_SHIFT;

  sat_add #(.W(FIX_W), .LIMIT(VEL_MAX)) u_acc_add (
    .a (vel_base),
    .b (i_accel),
    .y (acc_sum)
  );

  sat_add #(.W(FIX_W), .LIMIT(VEL_MAX)) u_refl_add (
    .a (vel_neg),
    .b (vel_damp),
    .y (refl_sum)
  );

  assign hit_wall = ((i_pos <= POS_MIN) && (vel_q < 0)) ||
                    ((i_pos >= POS_MAX) && (vel_q > 0));

  always_ff @(posedge CLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      vel_q     <= '0;
      bounce_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vel_q     <= vel_d;
      bounce_q  <= bounce_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    vel_d     = vel_q;
    bounce_d  = 1'b0;
    overrun_d = 1'b0;
    if (i_hold) begin
      state_d = IDLE;
      vel_d   = '0;
    end else begin
      if (i_tick && state_q != IDLE)
        overrun_d = 1'b1;
      case (state_q)
        IDLE:  if (i_tick) state_d = ACCEL;
        ACCEL: begin
          vel_d   = acc_sum;
          state_d = CHECK;
        end
        CHECK: begin
          if (hit_wall) begin
            vel_d    = refl_sum;
            bounce_d = 1'b1;
          end
          state_d = ISSUE;
        end
        ISSUE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign o_velocity  = vel_q;
  assign o_calc_time = (state_q == ISSUE);
  assign o_busy      = (state_q != IDLE);
  assign o_bounce    = bounce_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_velocity_ctrl.sv
// Scoreboard bench for velocity_ctrl: frames push expected velocity/bounce, a monitor checks each strobe.
module tb_velocity_ctrl;

  logic               CLK = 1'b0;
  logic               i_rst_n;
  logic               i_tick;
  logic signed [31:0] i_accel;
  logic signed [31:0] i_pos;
  logic               i_hold;
  logic signed [31:0] o_velocity;
  logic               o_calc_time, o_bounce, o_overrun, o_busy;

  velocity_ctrl #(
    .POSITION_SHIFT (4),
    .POS_MIN        (0),
    .POS_MAX        (100),
    .VEL_MAX        (64),
    .DAMP_SHIFT     (1),
    .FRICTION_SHIFT (3)
  ) dut (
    .CLK         (CLK),
    .i_rst_n     (i_rst_n),
    .i_tick      (i_tick),
    .i_accel     (i_accel),
    .i_pos       (i_pos),
    .i_hold      (i_hold),
    .o_velocity  (o_velocity),
    .o_calc_time (o_calc_time),
    .o_bounce    (o_bounce),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string              name;
    logic signed [31:0] vel;
    logic               bounce;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (i_rst_n === 1'b1 && o_calc_time === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: got strobe with velocity %0d, expected none", o_velocity);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_vel"}, o_velocity, e.vel);
        check({e.name, "_bounce"}, {31'd0, o_bounce}, {31'd0, e.bounce});
      end
    end
  end

  task automatic frame(input string name, input int accel, input int pos,
                       input int exp_v, input bit exp_b);
    exp_t e;
    @(posedge CLK); #1;
    i_accel = accel;
    i_pos   = pos;
    i_tick  = 1'b1;
    e.name = name; e.vel = exp_v; e.bounce = exp_b;
    sb.push_back(e);
    @(posedge CLK); #1;
    i_tick = 1'b0;
    repeat (4) @(posedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst_n = 1'b0; i_tick = 1'b0; i_hold = 1'b0;
    i_accel = '0;   i_pos = 32'sd50;
    repeat (3) @(posedge CLK); #1;
    check("rst_vel",  o_velocity, 0);
    check("rst_busy", {31'd0, o_busy}, 0);
    check("rst_calc", {31'd0, o_calc_time}, 0);
    check("rst_flags", {30'd0, o_bounce, o_overrun}, 0);
    i_rst_n = 1'b1;
    repeat (2) @(posedge CLK);

    // Basic frame with explicit cycle-level checks.
    begin
      exp_t e;
      @(posedge CLK); #1;
      i_accel = 5; i_tick = 1'b1;
      e.name = "basic"; e.vel = 5; e.bounce = 1'b0;
      sb.push_back(e);
      @(posedge CLK); #1;   // ACCEL
      i_tick = 1'b0;
      check("basic_busy", {31'd0, o_busy}, 1);
      check("basic_vel_pre", o_velocity, 0);
      @(posedge CLK); #1;   // CHECK
      check("basic_vel_c2", o_velocity, 5);
      check("basic_calc_c2", {31'd0, o_calc_time}, 0);
      @(posedge CLK); #1;   // ISSUE
      check("basic_calc_c3", {31'd0, o_calc_time}, 1);
      @(posedge CLK); #1;   // IDLE
      check("basic_calc_c4", {31'd0, o_calc_time}, 0);
      check("basic_idle", {31'd0, o_busy}, 0);
      repeat (2) @(posedge CLK);
    end

    frame("to60",      55,   50,  60, 1'b0);
    frame("sat_pos",   10,   50,  64, 1'b0);
    frame("sat_neg",  -200,  50, -64, 1'b0);
    frame("to40",     104,   50,  40, 1'b0);
    frame("bounce_hi",  0,  100, -20, 1'b1);
    frame("inward_hi", 12,  100,  -8, 1'b0);
    frame("to_m33",   -25,   50, -33, 1'b0);
    frame("bounce_lo",  0,   -2,  16, 1'b1);
    frame("inward_lo",  0,    0,  16, 1'b0);
    frame("zero_wall", -16, 100,   0, 1'b0);

    // Overrun: ticks on two consecutive cycles, only the first is taken.
    begin
      exp_t e;
      @(posedge CLK); #1;
      i_accel = 3; i_pos = 50; i_tick = 1'b1;
      e.name = "overrun"; e.vel = 3; e.bounce = 1'b0;
      sb.push_back(e);
      @(posedge CLK); #1;
      check("overrun_early", {31'd0, o_overrun}, 0);
      @(posedge CLK); #1;
      i_tick = 1'b0;
      check("overrun_pulse", {31'd0, o_overrun}, 1);
      @(posedge CLK); #1;
      check("overrun_clear", {31'd0, o_overrun}, 0);
      repeat (4) @(posedge CLK);
    end

    frame("to30", 27, 50, 30, 1'b0);

    // Hold in IDLE together with a tick: clears velocity, no frame, no overrun.
    @(posedge CLK); #1;
    i_hold = 1'b1; i_tick = 1'b1;
    @(posedge CLK); #1;
    i_hold = 1'b0; i_tick = 1'b0;
    check("hold_vel", o_velocity, 0);
    check("hold_busy", {31'd0, o_busy}, 0);
    check("hold_overrun", {31'd0, o_overrun}, 0);
    repeat (4) @(posedge CLK);

    // Hold mid-frame aborts it without a strobe.
    @(posedge CLK); #1;
    i_accel = 9; i_tick = 1'b1;
    @(posedge CLK); #1;
    i_tick = 1'b0; i_hold = 1'b1;
    @(posedge CLK); #1;
    i_hold = 1'b0;
    check("hold_mid_vel", o_velocity, 0);
    check("hold_mid_busy", {31'd0, o_busy}, 0);
    repeat (4) @(posedge CLK);

    // Asynchronous reset during CHECK.
    @(posedge CLK); #1;
    i_accel = 7; i_tick = 1'b1;
    @(posedge CLK); #1;
    i_tick = 1'b0;
    @(posedge CLK); #1;
    check("areset_pre_vel", o_velocity, 7);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("areset_vel", o_velocity, 0);
    check("areset_busy", {31'd0, o_busy}, 0);
    repeat (2) @(posedge CLK);
    #3;
    i_rst_n = 1'b1;
    repeat (3) @(posedge CLK);

    frame("fresh", 2, 50, 2, 1'b0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge CLK);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/velocity_ctrl.md
Name: velocity_ctrl

Overview:
- Frame-rate velocity engine for the teeter ball; the velocity-producing end of the velocity/position interface.
- On each frame tick it integrates the tilt acceleration into a signed fixed-point velocity, saturates it, and reflects it at the position bounds.
- It then pulses o_calc_time so the downstream position integrator adds o_velocity.
- It reads back that integrator's integer position output on i_pos.

Parameters:
- POSITION_SHIFT, 4, fractional bits of velocity/acceleration; must match the position integrator.
- POS_MIN, 0, lower wall in integer position units.
- POS_MAX, 100, upper wall in integer position units.
- VEL_MAX, 64, velocity magnitude limit in raw fixed-point LSBs (64 = 4.0 units/frame).
- DAMP_SHIFT, 1, bounce loss; reflected v = -v + (v>>>DAMP_SHIFT); legal range 1..31.
- FRICTION_SHIFT, 3, friction divisor exponent (used only with the optional feature).

Ports:
- CLK  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_tick  in  1  frame tick, single-cycle pulse.
- i_accel  in  32  signed fixed-point acceleration (POSITION_SHIFT fraction).
- i_pos  in  32  signed integer ball position (sign-extended, fraction removed).
- i_hold  in  1  synchronous clear: velocity to 0, FSM to IDLE.
- o_velocity  out  32  signed fixed-point velocity.
- o_calc_time  out  1  one-cycle strobe telling the integrator to add o_velocity.
- o_bounce  out  1  one-cycle pulse when a reflection is applied.
- o_overrun  out  1  one-cycle pulse when a tick is dropped.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (i_rst_n=0, asynchronous): state=IDLE; o_velocity=0; o_calc_time, o_bounce, o_overrun, o_busy all 0. Reset mid-operation aborts the frame and issues no strobe.
- Priority: reset > i_hold > FSM.
- i_hold=1: o_velocity<=0 and state<=IDLE on the next edge; an i_tick in the same cycle is ignored and is not counted as an overrun.
- FSM states, 2-bit: IDLE, ACCEL, CHECK, ISSUE.
  - IDLE: on i_tick go to ACCEL.
  - ACCEL: v <= sat(v + i_accel); go to CHECK.
  - CHECK: compare i_pos with the bounds.
    - If (i_pos <= POS_MIN and v < 0) or (i_pos >= POS_MAX and v > 0): v <= -v + (v>>>DAMP_SHIFT), o_bounce=1 on the next cycle.
    - Otherwise v is unchanged.
    - Go to ISSUE.
  - ISSUE: o_calc_time=1 for exactly this cycle; go to IDLE.
- Latency: tick sampled at edge t gives o_calc_time high in cycle t+3. Back-to-back ticks are accepted with a 4-cycle spacing.
- i_tick while o_busy=1: tick dropped, o_overrun pulses the following cycle, FSM unaffected.
- Saturation: sum computed in 33 bits, clamped to [-VEL_MAX, +VEL_MAX]; the reflected value is also clamped.
- Exactly at a wall with velocity pointing inward: no reflection.
- i_pos at or beyond a wall with v=0: no reflection.
- o_velocity is stable from the end of CHECK through ISSUE.

Optional Feature:
- Macro: VELOCITY_FRICTION_EN.
- Defined: ACCEL computes v <= sat(v + i_accel - (v>>>FRICTION_SHIFT)), with friction applied before the clamp.
- Undefined: no friction term; FRICTION_SHIFT is unused.
- Latency is identical either way.

Decomposition:
- Package teeter_pkg holds:
  - the FSM state typedef (IDLE/ACCEL/CHECK/ISSUE);
  - POSITION_SHIFT default;
  - default POS_MIN/POS_MAX;
  - 32-bit fixed-point word width constant.
- Sub-module sat_add: combinational 32+32 signed add with a symmetric ±LIMIT clamp. It is instanced for the ACCEL sum and for the reflected value.

Test Plan:
- Basic frame: reset, i_pos=50, i_accel=5, tick at cycle 10 → o_velocity=5 from cycle 12; o_calc_time high only in cycle 13; o_bounce=0.
- Saturation: v=60, i_accel=10, tick → o_velocity=64. Then i_accel=-200, tick → o_velocity=-64.
- Upper bounce: v=40, i_accel=0, i_pos=100, DAMP_SHIFT=1, tick → o_velocity=-20, o_bounce pulse in cycle t+3, o_calc_time in cycle t+3. Same setup with v=-8 → v stays -8, no bounce.
- Lower bounce: v=-33, i_pos=-2 → o_velocity=33+(-33>>>1)=16, o_bounce pulse.
- Overrun and hold:
  - tick at t and t+1 → one o_calc_time at t+3, o_overrun at t+2;
  - i_hold with v=30 → v=0 next cycle, FSM IDLE, no strobe.
- Async reset mid-frame: drive i_rst_n low between clock edges during CHECK → o_velocity=0 and o_busy=0 immediately (no clock edge required); no o_calc_time afterwards; the next tick behaves as a fresh frame.
